dsp_issue_sequencer: RTL and testbench

Upstream control stage for the fused multiply-accumulate datapath (DSP_top). It accepts one operation request per valid/ready handshake and registers its operands. It then drives the datapath's `start`/`mode`/operand pins for the number of beats the selected mode needs. Finally it captures the datapath result into a held output register, which it presents on a second valid/ready handshake.

---
 rtl/dsp_pkg.sv | 30 +++
 rtl/dsp_issue_sequencer_if.sv | 28 ++
 rtl/dsp_issue_sequencer.sv | 125 ++++++++++++
 tb/tb_dsp_issue_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared encodings and helpers for the DSP issue sequencer.
package dsp_pkg;

  localparam int unsigned RES_LAT_MAX = 3;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [1:0] {
    MODE_HALF = 2'd0,
    MODE_A9   = 2'd1,
    MODE_FULL = 2'd2,
    MODE_ILL  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  // Number of issue beats the datapath needs for a mode; illegal mode issues as one beat.
  function automatic logic [2:0] beats_for_mode(input logic [1:0] mode);
    case (mode)
      MODE_A9:   beats_for_mode = 3'd2;
      MODE_FULL: beats_for_mode = 3'd4;
      default:   beats_for_mode = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dsp_issue_sequencer_if.sv
// Request and result handshakes between a requester and the issue sequencer.
interface dsp_issue_sequencer_if #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [N-1:0]     req_a;
  logic [M-1:0]     req_b;
  logic [N+M-1:0]   req_c;
  logic             req_mac;
  logic [1:0]       req_shift;
  logic             res_valid;
  logic             res_ready;
  logic [N+M-1:0]   res_data;
  logic             res_err;

  modport master (
    output req_valid, req_mode, req_a, req_b, req_c, req_mac, req_shift, res_ready,
    input  req_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, req_c, req_mac, req_shift, res_ready,
    output req_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/dsp_issue_sequencer.sv
// Issues one request to the MAC datapath for the mode's beat count and holds the result.
module dsp_issue_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned M       = 16,
  parameter int unsigned RES_LAT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dsp_issue_sequencer_if.slave bus,
  output logic                 dsp_start,
  output logic                 dsp_mac,
  output logic [1:0]           dsp_mode,
  output logic [1:0]           dsp_barrel_shifter,
  output logic [N-1:0]         dsp_aa,
  output logic [M-1:0]         dsp_bb,
  output logic [N+M-1:0]       dsp_cc,
  input  logic [N+M-1:0]       dsp_out,
  output logic                 busy
);

  localparam int unsigned W = N + M;
  localparam logic HAS_WAIT = (RES_LAT != 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (RES_LAT != 0) ? CNT_W'(RES_LAT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     a_q;
  logic [M-1:0]     b_q;
  logic [W-1:0]     c_q;
  logic [W-1:0]     res_q;
  logic [1:0]       mode_q;
  logic [1:0]       shift_q;
  logic             mac_q;
  logic             start_q;
  logic             err_q;
  logic             accept;
  logic             capture;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign capture = (state_d == S_HOLD) && (state_q != S_HOLD);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; the beat/latency counter reaching zero ends ISSUE and WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_ISSUE;
      S_ISSUE: if (cnt_q == '0)   state_d = HAS_WAIT ? S_WAIT : S_HOLD;
      S_WAIT:  if (cnt_q == '0)   state_d = S_HOLD;
      S_HOLD:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, shared down-counter and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      mode_q  <= '0;
      shift_q <= '0;
      mac_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.req_a;
        b_q     <= bus.req_b;
        c_q     <= bus.req_c;
        mac_q   <= bus.req_mac;
        shift_q <= bus.req_shift;
        mode_q  <= (bus.req_mode == MODE_ILL) ? 2'(MODE_HALF) : bus.req_mode;
        err_q   <= (bus.req_mode == MODE_ILL);
        start_q <= 1'b1;
        cnt_q   <= CNT_W'(beats_for_mode(bus.req_mode) - 3'd1);
      end else if (state_q == S_ISSUE) begin
        start_q <= 1'b0;
        cnt_q   <= (cnt_q == '0) ? WAIT_LOAD : cnt_q - CNT_W'(1);
      end else if (state_q == S_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) res_q <= dsp_out;
    end
  end

  // Output decode; datapath pins carry operands only while ISSUE/WAIT.
  always_comb begin
    bus.req_ready      = 1'b0;
    bus.res_valid      = 1'b0;
    busy               = (state_q != S_IDLE);
    dsp_start          = 1'b0;
    dsp_mode           = '0;
    dsp_aa             = '0;
    dsp_bb             = '0;
    dsp_cc             = '0;
    dsp_mac            = mac_q;
    dsp_barrel_shifter = shift_q;
    case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_ISSUE, S_WAIT: begin
        dsp_start = start_q && (state_q == S_ISSUE);
        dsp_mode  = mode_q;
        dsp_aa    = a_q;
        dsp_bb    = b_q;
        dsp_cc    = c_q;
      end
      S_HOLD: bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.res_data = res_q;
  assign bus.res_err  = err_q;

endmodule

// File: tb/tb_dsp_issue_sequencer.sv
// Directed bench: two sequencers (RES_LAT 0 and 2) each driving a behavioural MAC model.
module tb_dsp_issue_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Requester-side drive, index 0 -> RES_LAT=0 instance, 1 -> RES_LAT=2 instance.
  logic [1:0]  rv, rrdy;
  logic [1:0]  rmode [2];
  logic [15:0] ra [2], rb [2];
  logic [31:0] rc [2];

  dsp_issue_sequencer_if #(.N(16), .M(16)) bus0 ();
  dsp_issue_sequencer_if #(.N(16), .M(16)) bus2 ();

  assign bus0.req_valid = rv[0];   assign bus2.req_valid = rv[1];
  assign bus0.req_mode  = rmode[0]; assign bus2.req_mode = rmode[1];
  assign bus0.req_a     = ra[0];   assign bus2.req_a     = ra[1];
  assign bus0.req_b     = rb[0];   assign bus2.req_b     = rb[1];
  assign bus0.req_c     = rc[0];   assign bus2.req_c     = rc[1];
  assign bus0.req_mac   = 1'b0;    assign bus2.req_mac   = 1'b0;
  assign bus0.req_shift = 2'd0;    assign bus2.req_shift = 2'd0;
  assign bus0.res_ready = rrdy[0]; assign bus2.res_ready = rrdy[1];

  logic        start0, start2, mac0, mac2, busy0, busy2;
  logic [1:0]  mode0, mode2, sh0, sh2;
  logic [15:0] aa0, aa2, bb0, bb2;
  logic [31:0] cc0, cc2, out0, out2, p1, p2;

  dsp_issue_sequencer #(.N(16), .M(16), .RES_LAT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .dsp_start(start0), .dsp_mac(mac0), .dsp_mode(mode0), .dsp_barrel_shifter(sh0),
    .dsp_aa(aa0), .dsp_bb(bb0), .dsp_cc(cc0), .dsp_out(out0), .busy(busy0)
  );

  dsp_issue_sequencer #(.N(16), .M(16), .RES_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .dsp_start(start2), .dsp_mac(mac2), .dsp_mode(mode2), .dsp_barrel_shifter(sh2),
    .dsp_aa(aa2), .dsp_bb(bb2), .dsp_cc(cc2), .dsp_out(out2), .busy(busy2)
  );

  // Behavioural datapath: product per mode plus C (accumulate path is not exercised).
  function automatic logic [31:0] dp_f(input logic [1:0] m, input logic [15:0] a,
                                       input logic [15:0] b, input logic [31:0] c);
    logic signed [31:0] sa, sb;
    logic [31:0] ua, ub;
    case (m)
      2'd1: begin
        sa = 32'(signed'(a[8:0]));
        sb = 32'(signed'(b));
        dp_f = 32'(sa * sb) + c;
      end
      2'd2: begin
        sa = 32'(signed'(a));
        sb = 32'(signed'(b));
        dp_f = 32'(sa * sb) + c;
      end
      default: begin
        ua = {23'd0, a[8:0]};
        ub = {23'd0, b[8:0]};
        dp_f = ua * ub + c;
      end
    endcase
  endfunction

  assign out0 = dp_f(mode0, aa0, bb0, cc0);

  // Two-stage result pipe models RES_LAT=2.
  always_ff @(posedge clk) begin
    p1 <= dp_f(mode2, aa2, bb2, cc2);
    p2 <= p1;
  end
  assign out2 = p2;

  // Observation muxes.
  logic [1:0]  m_rdy, m_rvalid, m_err, m_busy, m_start;
  logic [31:0] m_data [2];
  logic [1:0]  m_mode [2];
  logic [15:0] m_aa [2];
  assign m_rdy    = {bus2.req_ready, bus0.req_ready};
  assign m_rvalid = {bus2.res_valid, bus0.res_valid};
  assign m_err    = {bus2.res_err, bus0.res_err};
  assign m_busy   = {busy2, busy0};
  assign m_start  = {start2, start0};
  assign m_data[0] = bus0.res_data; assign m_data[1] = bus2.res_data;
  assign m_mode[0] = mode0;         assign m_mode[1] = mode2;
  assign m_aa[0]   = aa0;           assign m_aa[1]   = aa2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present a request and wait (bounded) for its acceptance edge; returns #1 after it.
  task automatic issue(input int w, input logic [1:0] mode, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] c, input string tag);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    rv[w] = 1'b1; rmode[w] = mode; ra[w] = a; rb[w] = b; rc[w] = c;
    for (int i = 0; i < 20; i++) begin
      if (m_rdy[w]) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " accept"}, 32'(ok), 32'd1);
    #1;
    rv[w] = 1'b0;
  endtask

  // Full operation: beat/start profile, result timing, data, err, optional backpressure.
  task automatic run_op(input int w, input logic [1:0] mode, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] c, input int nb,
                        input int lat, input logic [31:0] exp_data, input logic exp_err,
                        input int hold, input string tag);
    int starts, rise;
    logic bad;
    logic [1:0] exp_mode;
    exp_mode = (mode == 2'd3) ? 2'd0 : mode;
    rrdy[w] = (hold == 0);
    issue(w, mode, a, b, c, tag);
    starts = 0;
    rise = 0;
    for (int e = 1; e <= nb + lat + 1; e++) begin
      if (e == 1) begin
        check({tag, " dsp_mode"}, 32'(m_mode[w]), 32'(exp_mode));
        check({tag, " dsp_aa"}, 32'(m_aa[w]), 32'(a));
      end
      if (m_start[w]) starts++;
      if (m_rvalid[w] && rise == 0) rise = e;
      if (e < nb + lat + 1) begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, " start beats"}, 32'(starts), 32'd1);
    check({tag, " res_valid cycle"}, 32'(rise), 32'(nb + lat + 1));
    check({tag, " res_data"}, m_data[w], exp_data);
    check({tag, " res_err"}, 32'(m_err[w]), 32'(exp_err));
    if (hold > 0) begin
      bad = 1'b0;
      rv[w] = 1'b1; rmode[w] = 2'd2; ra[w] = 16'h1234; rb[w] = 16'h0042; rc[w] = 32'd9;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        if (m_data[w] !== exp_data || m_rdy[w] || !m_rvalid[w] || m_start[w]) bad = 1'b1;
      end
      check({tag, " hold stable"}, 32'(bad), 32'd0);
      rv[w] = 1'b0;
      rrdy[w] = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " back to idle"}, {30'd0, m_rdy[w], m_rvalid[w]}, 32'd2);
  endtask

  initial begin
    logic pulsed;
    reset_n = 1'b0;
    rv = 2'b11; rrdy = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rmode[i] = 2'd2; ra[i] = 16'd7; rb[i] = 16'd7; rc[i] = 32'd1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(m_rdy), 32'd3);
    check("reset busy", 32'(m_busy), 32'd0);
    check("reset res_valid", 32'(m_rvalid), 32'd0);
    check("reset res_data", m_data[0], 32'd0);
    rv = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    run_op(0, 2'd0, 16'd3, 16'd5, 32'd7, 1, 0, 32'd22, 1'b0, 0, "m0");
    run_op(0, 2'd2, 16'hFFFE, 16'd300, 32'd0, 4, 0, 32'hFFFF_FDA8, 1'b0, 0, "m2");
    run_op(1, 2'd1, 16'd100, 16'hFFFD, 32'd1000, 2, 2, 32'd700, 1'b0, 0, "m1 lat2");
    run_op(0, 2'd0, 16'd4, 16'd6, 32'd10, 1, 0, 32'd34, 1'b0, 10, "bp");
    run_op(0, 2'd3, 16'd2, 16'd2, 32'd1, 1, 0, 32'd5, 1'b1, 0, "m3");

    // Abort a mode-2 operation on its third beat.
    rrdy[0] = 1'b1;
    issue(0, 2'd2, 16'hFFFE, 16'd300, 32'd0, "abort");
    repeat (2) @(posedge clk);
    #1;
    check("abort mid-issue busy", 32'(m_busy[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort outputs", {26'd0, m_busy[0], m_start[0], m_rvalid[0], m_err[0], m_rdy[0], (aa0 != 0)}, 32'd2);
    check("abort res_data", m_data[0], 32'd0);
    pulsed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (m_rvalid[0] || m_busy[0]) pulsed = 1'b1;
    end
    check("abort no res_valid", 32'(pulsed), 32'd0);
    run_op(0, 2'd0, 16'd3, 16'd5, 32'd7, 1, 0, 32'd22, 1'b0, 0, "after reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
